// File: rtl/serial_cmp_ctrl_pkg.sv
// serial_cmp_pkg: shared types and constants for the serial slice comparator controller
// Contents: state_e (FSM states), RES_G/RES_E/RES_L one-hot {g,e,l} encodings, SLICE_DEF default slice width.
package serial_cmp_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_e;
  localparam logic [2:0] RES_G = 3'b100;
  localparam logic [2:0] RES_E = 3'b010;
  localparam logic [2:0] RES_L = 3'b001;
  localparam int SLICE_DEF = 2;
endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// serial_cmp_ctrl_if: start/result handshake bundle between requester and serial_cmp_ctrl
// Requester -> controller: start_valid, a, b (W bits), res_ready.
// Controller -> requester: start_ready, res_valid, g/e/l, cycles ($clog2(W/SLICE+1) bits), busy.
// master: requester view; slave: controller view.
interface serial_cmp_ctrl_if import serial_cmp_pkg::*; #(parameter int W = 8, parameter int SLICE = SLICE_DEF);
  logic start_valid, start_ready, res_valid, res_ready, g, e, l, busy;
  logic [W-1:0] a, b;
  logic [$clog2(W/SLICE+1)-1:0] cycles;
  modport master(output start_valid, a, b, res_ready, input start_ready, res_valid, g, e, l, cycles, busy);
  modport slave(input start_valid, a, b, res_ready, output start_ready, res_valid, g, e, l, cycles, busy);
endinterface

// File: rtl/serial_cmp_ctrl_cmp_slice.sv
// cmp_slice: combinational SLICE-bit unsigned magnitude comparator
// Ports: x, y (SLICE bits) in; gt, eq, lt out, exactly one high.
module cmp_slice import serial_cmp_pkg::*; #(parameter int SLICE = SLICE_DEF) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  assign gt = x > y;
  assign eq = x == y;
  assign lt = x < y;
endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: compares two W-bit operands MSB-first, one SLICE-bit slice per cycle
// Ports: clk, rst_n (sync, active-low), bus (serial_cmp_ctrl_if.slave: start handshake with a/b,
// result handshake with one-hot g/e/l, cycles used, busy).
// Build option: CMP_SIGNED_EN treats operands as two's complement.
module serial_cmp_ctrl import serial_cmp_pkg::*; #(
  parameter int W     = 8,
  parameter int SLICE = SLICE_DEF
) (
  input logic              clk,
  input logic              rst_n,
  serial_cmp_ctrl_if.slave bus
);
  localparam int N  = W / SLICE;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  if (W % SLICE != 0 || W < SLICE) begin : g_bad_width
    $error("serial_cmp_ctrl: W must be a positive multiple of SLICE");
  end
  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic [2:0]      res_q, res_d;
  logic            start_ready_q, start_ready_d, res_valid_q, res_valid_d, busy_q, busy_d;
  logic [SLICE-1:0] sa, sb;
  logic            gt, eq, lt, last;
  assign sa   = a_q[idx_q*SLICE +: SLICE];
  assign sb   = b_q[idx_q*SLICE +: SLICE];
  assign last = idx_q == '0;
  cmp_slice #(.SLICE(SLICE)) u_slice (.x(sa), .y(sb), .gt(gt), .eq(eq), .lt(lt));
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    cycles_d = cycles_q;
    res_d    = res_q;
    if (state_q == IDLE && bus.start_valid) begin
`ifdef CMP_SIGNED_EN
      // flipping the sign bit maps two's complement order onto unsigned order
      a_d = bus.a ^ (W'(1) << (W - 1));
      b_d = bus.b ^ (W'(1) << (W - 1));
`else
      a_d = bus.a;
      b_d = bus.b;
`endif
      idx_d    = IW'(N - 1);
      cycles_d = '0;
      state_d  = COMPARE;
    end else if (state_q == COMPARE) begin
      cycles_d = cycles_q + CW'(1);
      idx_d    = idx_q - IW'(1);
      res_d    = gt ? RES_G : lt ? RES_L : last ? RES_E : '0;
      state_d  = (!eq || last) ? DONE : COMPARE;
    end else if (state_q == DONE && bus.res_ready) begin
      res_d   = '0;
      state_d = IDLE;
    end
    start_ready_d = state_d == IDLE;
    res_valid_d   = state_d == DONE;
    busy_d        = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      idx_q         <= '0;
      cycles_q      <= '0;
      res_q         <= '0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      idx_q         <= idx_d;
      cycles_q      <= cycles_d;
      res_q         <= res_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end
  assign bus.start_ready       = start_ready_q;
  assign bus.res_valid         = res_valid_q;
  assign {bus.g, bus.e, bus.l} = res_q;
  assign bus.cycles            = cycles_q;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb_serial_cmp_ctrl: self-checking bench for serial_cmp_ctrl (W=8, SLICE=2)
module tb_serial_cmp_ctrl;
  localparam int W = 8, S = 2, N = W / S;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  serial_cmp_ctrl_if #(.W(W), .SLICE(S)) bus();
  serial_cmp_ctrl #(.W(W), .SLICE(S)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] r;
    int         cy;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int exp_k(input logic [7:0] x, input logic [7:0] y);
    for (int k = 1; k <= N; k++)
      if (((x ^ y) >> (W - S * k)) != 0) return k;
    return N;
  endfunction
  function automatic logic [2:0] exp_res(input logic [7:0] x, input logic [7:0] y);
`ifdef CMP_SIGNED_EN
    return ($signed(x) > $signed(y)) ? 3'b100 : ($signed(x) < $signed(y)) ? 3'b001 : 3'b010;
`else
    return (x > y) ? 3'b100 : (x < y) ? 3'b001 : 3'b010;
`endif
  endfunction
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input int hold,
                        output logic [2:0] r, output int cy, output int lat);
    int n;
    n = 0;
    while (!bus.start_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.start_ready) chk("start_ready_timeout", bus.start_ready, 1);
    bus.a = ia;
    bus.b = ib;
    bus.start_valid = 1'b1;
    bus.res_ready = (hold == 0);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      chk("gel_zero_while_busy", {bus.g, bus.e, bus.l}, 0);
      chk("busy_in_compare", bus.busy, 1);
      @(posedge clk); #1; lat++;
    end
    chk("res_valid_seen", bus.res_valid, 1);
    r = {bus.g, bus.e, bus.l};
    cy = int'(bus.cycles);
    chk("onehot", $countones(r), 1);
    for (int i = 0; i < hold; i++) begin
      bus.start_valid = i[0];
      bus.a = 8'($urandom);
      chk("hold_start_ready", bus.start_ready, 0);
      @(posedge clk); #1;
      chk("hold_res_valid", bus.res_valid, 1);
      chk("hold_gel", {bus.g, bus.e, bus.l}, r);
      chk("hold_cycles", bus.cycles, cy);
    end
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("idle_start_ready", bus.start_ready, 1);
    chk("idle_res_valid", bus.res_valid, 0);
    chk("idle_gel", {bus.g, bus.e, bus.l}, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] r;
    int cy, lat;
    logic [7:0] ra, rb;
    tbl[0] = '{8'hA5, 8'h35, 3'b100, 1};
    tbl[1] = '{8'h3C, 8'h3C, 3'b010, 4};
    tbl[2] = '{8'h34, 8'h35, 3'b001, 4};
    tbl[3] = '{8'h01, 8'h02, 3'b001, 4};
    tbl[4] = '{8'hFF, 8'h00, 3'b100, 1};
`ifdef CMP_SIGNED_EN
    tbl[5] = '{8'h80, 8'h01, 3'b001, 1};
`else
    tbl[5] = '{8'h80, 8'h01, 3'b100, 1};
`endif
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", bus.start_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_gel", {bus.g, bus.e, bus.l}, 0);
    chk("rst_cycles", bus.cycles, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, 0, r, cy, lat);
      chk($sformatf("vec%0d_res", i), r, tbl[i].r);
      chk($sformatf("vec%0d_cycles", i), cy, tbl[i].cy);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].cy + 1);
    end
    run_op(8'h01, 8'h02, 5, r, cy, lat);
    chk("hold_seq_res", r, 3'b001);
    chk("hold_seq_cycles", cy, 4);
    bus.a = 8'h00;
    bus.b = 8'hFF;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    chk("abort_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_start_ready", bus.start_ready, 1);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_gel", {bus.g, bus.e, bus.l}, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_result", bus.res_valid, 0);
    end
    run_op(8'hFF, 8'h00, 0, r, cy, lat);
    chk("post_abort_res", r, 3'b100);
    chk("post_abort_cycles", cy, 1);
    for (int t = 0; t < 200; t++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run_op(ra, rb, $urandom_range(0, 3), r, cy, lat);
      chk($sformatf("rand_res a=%0h b=%0h", ra, rb), r, exp_res(ra, rb));
      chk($sformatf("rand_cycles a=%0h b=%0h", ra, rb), cy, exp_k(ra, rb));
      chk($sformatf("rand_latency a=%0h b=%0h", ra, rb), lat, exp_k(ra, rb) + 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
